// File: rtl/dwc_pcie_axi_slv_req_arb_pkg.sv
// Shared types and constants for the AXI slave AW/AR request arbiter.
package pkg_axi_slv_arb;

  localparam int unsigned ARB_ADDR_W = 64;
  localparam int unsigned ARB_ID_W   = 8;
  localparam int unsigned ARB_LEN_W  = 8;

  localparam logic ARB_PTR_RD = 1'b0;
  localparam logic ARB_PTR_WR = 1'b1;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  is_wr;
    logic [ARB_ID_W-1:0]   id;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_LEN_W-1:0]  len;
  } arb_req_s;

endpackage

// File: rtl/dwc_pcie_axi_slv_req_arb_os_cnt.sv
// Saturating outstanding-transaction counter with a limit compare and sticky underflow.
module dwc_pcie_axi_slv_os_cnt #(
  parameter int unsigned MAX_OS = 16,
  parameter int unsigned CW     = $clog2(MAX_OS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          below_max_c,
  output logic          underflow
);

  assign below_max_c = (cnt < CW'(MAX_OS));

  // A decrement at zero is a protocol error: hold at zero and flag it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      underflow <= 1'b0;
    end else if (inc && !dec) begin
      cnt <= cnt + CW'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) begin
        underflow <= 1'b1;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/dwc_pcie_axi_slv_req_arb.sv
// Weighted round-robin AW/AR arbiter onto one registered request path, with
// outstanding limits and quiesce. DWC_PCIE_AXI_SLV_ARB_STATS_EN adds grant/stall counters.
module dwc_pcie_axi_slv_req_arb
  import pkg_axi_slv_arb::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned MAX_WR_OS  = 16,
  parameter int unsigned MAX_RD_OS  = 16,
  parameter int unsigned WR_WEIGHT  = 1,
  parameter int unsigned RD_WEIGHT  = 1,
  parameter type         req_t      = arb_req_s
) (
  input  logic                             slv_aclk,
  input  logic                             slv_rst,
  input  logic                             aw_valid,
  output logic                             aw_ready,
  input  logic [ID_WIDTH-1:0]              aw_id,
  input  logic [ADDR_WIDTH-1:0]            aw_addr,
  input  logic [LEN_WIDTH-1:0]             aw_len,
  input  logic                             ar_valid,
  output logic                             ar_ready,
  input  logic [ID_WIDTH-1:0]              ar_id,
  input  logic [ADDR_WIDTH-1:0]            ar_addr,
  input  logic [LEN_WIDTH-1:0]             ar_len,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic                             req_is_wr,
  output logic [ID_WIDTH-1:0]              req_id,
  output logic [ADDR_WIDTH-1:0]            req_addr,
  output logic [LEN_WIDTH-1:0]             req_len,
  input  logic                             b_done,
  input  logic                             r_last_done,
  input  logic                             quiesce_req,
  output logic                             quiesce_done,
  output logic [$clog2(MAX_WR_OS+1)-1:0]   wr_os_cnt,
  output logic [$clog2(MAX_RD_OS+1)-1:0]   rd_os_cnt,
  output logic                             os_underflow
`ifdef DWC_PCIE_AXI_SLV_ARB_STATS_EN
  ,
  output logic [31:0]                      wr_grant_cnt,
  output logic [31:0]                      rd_grant_cnt,
  output logic [31:0]                      stall_cnt
`endif
);

  localparam int unsigned WR_CW  = $clog2(MAX_WR_OS + 1);
  localparam int unsigned RD_CW  = $clog2(MAX_RD_OS + 1);
  localparam int unsigned MAX_WT = (WR_WEIGHT > RD_WEIGHT) ? WR_WEIGHT : RD_WEIGHT;
  localparam int unsigned CONS_W = $clog2(MAX_WT + 1);

  arb_state_e        state_q, state_d;
  req_t              req_q;
  logic              ptr_q, ptr_d;
  logic              last_dir_q;
  logic [CONS_W-1:0] cons_q, cons_d, cons_inc;
  logic              wr_below_c, rd_below_c;
  logic              wr_uf, rd_uf;
  logic              slot_c, wr_elig_c, rd_elig_c;
  logic              grant_wr_c, grant_rd_c, grant_c;

  // Credits come only from registered counts; same-cycle completions do not bypass.
  assign slot_c     = ((state_q == ARB_EMPTY) || req_ready) && !quiesce_req;
  assign wr_elig_c  = aw_valid && wr_below_c;
  assign rd_elig_c  = ar_valid && rd_below_c;
  assign grant_wr_c = slot_c && wr_elig_c && (!rd_elig_c || (ptr_q == ARB_PTR_WR));
  assign grant_rd_c = slot_c && rd_elig_c && (!wr_elig_c || (ptr_q == ARB_PTR_RD));
  assign grant_c    = grant_wr_c || grant_rd_c;

  assign aw_ready   = grant_wr_c;
  assign ar_ready   = grant_rd_c;

  assign req_valid  = (state_q == ARB_FULL);
  assign req_is_wr  = req_q.is_wr;
  assign req_id     = req_q.id;
  assign req_addr   = req_q.addr;
  assign req_len    = req_q.len;

  assign os_underflow = wr_uf || rd_uf;

  dwc_pcie_axi_slv_os_cnt #(.MAX_OS(MAX_WR_OS), .CW(WR_CW)) u_wr_os (
    .clk        (slv_aclk),
    .rst        (slv_rst),
    .inc        (grant_wr_c),
    .dec        (b_done),
    .cnt        (wr_os_cnt),
    .below_max_c(wr_below_c),
    .underflow  (wr_uf)
  );

  dwc_pcie_axi_slv_os_cnt #(.MAX_OS(MAX_RD_OS), .CW(RD_CW)) u_rd_os (
    .clk        (slv_aclk),
    .rst        (slv_rst),
    .inc        (grant_rd_c),
    .dec        (r_last_done),
    .cnt        (rd_os_cnt),
    .below_max_c(rd_below_c),
    .underflow  (rd_uf)
  );

  // Next state, plus weighted pointer: after WEIGHT same-direction grants point at the other side.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cons_d   = cons_q;
    cons_inc = (grant_wr_c == last_dir_q) ? (cons_q + CONS_W'(1)) : CONS_W'(1);
    case (state_q)
      ARB_EMPTY: if (grant_c) state_d = ARB_FULL;
      ARB_FULL:  if (req_ready && !grant_c) state_d = ARB_EMPTY;
      default:   state_d = ARB_EMPTY;
    endcase
    if (grant_c) begin
      if (cons_inc >= (grant_wr_c ? CONS_W'(WR_WEIGHT) : CONS_W'(RD_WEIGHT))) begin
        ptr_d  = ~grant_wr_c;
        cons_d = '0;
      end else begin
        cons_d = cons_inc;
      end
    end
  end

  always_ff @(posedge slv_aclk) begin
    if (slv_rst) begin
      state_q <= ARB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge slv_aclk) begin
    if (slv_rst) begin
      req_q        <= '0;
      ptr_q        <= ARB_PTR_RD;
      last_dir_q   <= ARB_PTR_RD;
      cons_q       <= '0;
      quiesce_done <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cons_q <= cons_d;
      if (grant_c) begin
        last_dir_q  <= grant_wr_c;
        req_q.is_wr <= grant_wr_c;
        req_q.id    <= grant_wr_c ? aw_id   : ar_id;
        req_q.addr  <= grant_wr_c ? aw_addr : ar_addr;
        req_q.len   <= grant_wr_c ? aw_len  : ar_len;
      end
      quiesce_done <= quiesce_req && (state_q == ARB_EMPTY) &&
                      (wr_os_cnt == '0) && (rd_os_cnt == '0);
    end
  end

`ifdef DWC_PCIE_AXI_SLV_ARB_STATS_EN
  logic stall_c;

  // A stall is an open slot where a pending valid lost only to its outstanding limit.
  assign stall_c = slot_c && ((aw_valid && !wr_below_c) || (ar_valid && !rd_below_c));

  always_ff @(posedge slv_aclk) begin
    if (slv_rst) begin
      wr_grant_cnt <= '0;
      rd_grant_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (grant_wr_c) wr_grant_cnt <= wr_grant_cnt + 32'd1;
      if (grant_rd_c) rd_grant_cnt <= rd_grant_cnt + 32'd1;
      if (stall_c)    stall_cnt    <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dwc_pcie_axi_slv_req_arb.sv
// Directed bench for the AXI slave request arbiter: dut_a (weights 1/1, 4 reads max)
// and dut_b (write weight 3) share one stimulus set.
module tb_dwc_pcie_axi_slv_req_arb;

  localparam int unsigned AW = 64;
  localparam int unsigned IW = 8;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          aw_valid, ar_valid, req_ready, b_done, r_last_done, quiesce_req;
  logic [IW-1:0] aw_id, ar_id;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [LW-1:0] aw_len, ar_len;

  logic          a_aw_ready, a_ar_ready, a_req_valid, a_req_is_wr, a_quiesce_done, a_os_underflow;
  logic [IW-1:0] a_req_id;
  logic [AW-1:0] a_req_addr;
  logic [LW-1:0] a_req_len;
  logic [4:0]    a_wr_os_cnt;
  logic [2:0]    a_rd_os_cnt;

  logic          b_aw_ready, b_ar_ready, b_req_valid, b_req_is_wr, b_quiesce_done, b_os_underflow;
  logic [IW-1:0] b_req_id;
  logic [AW-1:0] b_req_addr;
  logic [LW-1:0] b_req_len;
  logic [4:0]    b_wr_os_cnt;
  logic [4:0]    b_rd_os_cnt;

`ifdef DWC_PCIE_AXI_SLV_ARB_STATS_EN
  logic [31:0] a_wr_grant_cnt, a_rd_grant_cnt, a_stall_cnt;
  logic [31:0] b_wr_grant_cnt, b_rd_grant_cnt, b_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dwc_pcie_axi_slv_req_arb #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW),
    .MAX_WR_OS(16), .MAX_RD_OS(4), .WR_WEIGHT(1), .RD_WEIGHT(1)
  ) dut_a (
    .slv_aclk(clk), .slv_rst(rst),
    .aw_valid(aw_valid), .aw_ready(a_aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .ar_valid(ar_valid), .ar_ready(a_ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .req_valid(a_req_valid), .req_ready(req_ready), .req_is_wr(a_req_is_wr),
    .req_id(a_req_id), .req_addr(a_req_addr), .req_len(a_req_len),
    .b_done(b_done), .r_last_done(r_last_done),
    .quiesce_req(quiesce_req), .quiesce_done(a_quiesce_done),
    .wr_os_cnt(a_wr_os_cnt), .rd_os_cnt(a_rd_os_cnt), .os_underflow(a_os_underflow)
`ifdef DWC_PCIE_AXI_SLV_ARB_STATS_EN
    , .wr_grant_cnt(a_wr_grant_cnt), .rd_grant_cnt(a_rd_grant_cnt), .stall_cnt(a_stall_cnt)
`endif
  );

  dwc_pcie_axi_slv_req_arb #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW),
    .MAX_WR_OS(16), .MAX_RD_OS(16), .WR_WEIGHT(3), .RD_WEIGHT(1)
  ) dut_b (
    .slv_aclk(clk), .slv_rst(rst),
    .aw_valid(aw_valid), .aw_ready(b_aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .ar_valid(ar_valid), .ar_ready(b_ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .req_valid(b_req_valid), .req_ready(req_ready), .req_is_wr(b_req_is_wr),
    .req_id(b_req_id), .req_addr(b_req_addr), .req_len(b_req_len),
    .b_done(b_done), .r_last_done(r_last_done),
    .quiesce_req(quiesce_req), .quiesce_done(b_quiesce_done),
    .wr_os_cnt(b_wr_os_cnt), .rd_os_cnt(b_rd_os_cnt), .os_underflow(b_os_underflow)
`ifdef DWC_PCIE_AXI_SLV_ARB_STATS_EN
    , .wr_grant_cnt(b_wr_grant_cnt), .rd_grant_cnt(b_rd_grant_cnt), .stall_cnt(b_stall_cnt)
`endif
  );

  task automatic clear_inputs();
    aw_valid = 0; ar_valid = 0; req_ready = 0; b_done = 0; r_last_done = 0; quiesce_req = 0;
    aw_id = '0; ar_id = '0; aw_addr = '0; ar_addr = '0; aw_len = '0; ar_len = '0;
  endtask

  // Two reset edges; returns just after the last one with rst low.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk); #1;
    n_checks++; if (a_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b exp 0", a_req_valid); end
    n_checks++; if (a_req_is_wr !== 1'b0) begin n_fail++; $display("FAIL rst_req_is_wr got %b exp 0", a_req_is_wr); end
    n_checks++; if (a_req_id !== '0) begin n_fail++; $display("FAIL rst_req_id got %h exp 0", a_req_id); end
    n_checks++; if (a_req_addr !== '0) begin n_fail++; $display("FAIL rst_req_addr got %h exp 0", a_req_addr); end
    n_checks++; if (a_req_len !== '0) begin n_fail++; $display("FAIL rst_req_len got %h exp 0", a_req_len); end
    n_checks++; if (a_wr_os_cnt !== '0 || a_rd_os_cnt !== '0) begin n_fail++; $display("FAIL rst_os_cnt got %0d/%0d exp 0/0", a_wr_os_cnt, a_rd_os_cnt); end
    n_checks++; if (a_os_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_underflow got %b exp 0", a_os_underflow); end
    n_checks++; if (a_quiesce_done !== 1'b0) begin n_fail++; $display("FAIL rst_quiesce_done got %b exp 0", a_quiesce_done); end
    n_checks++; if (a_aw_ready !== 1'b0 || a_ar_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b%b exp 00", a_aw_ready, a_ar_ready); end
  endtask

  // Weights 1/1: strict alternation starting with read, one-cycle latency to req_valid.
  task automatic test_alternate();
    logic          exp_w, prev_w;
    logic [IW-1:0] exp_id;
    prev_w = 1'b0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      aw_valid = 1; ar_valid = 1; req_ready = 1;
      aw_id = IW'(16 + i); ar_id = IW'(32 + i);
      aw_addr = 64'h1000_0000_0000_0000 | AW'(i); ar_addr = 64'h2000_0000_0000_0000 | AW'(i);
      aw_len = LW'(i); ar_len = LW'(i + 8);
      #1;
      exp_w = (i % 2) == 1;
      n_checks++; if (a_aw_ready !== exp_w || a_ar_ready !== !exp_w) begin n_fail++; $display("FAIL alt_grant[%0d] got aw=%b ar=%b exp aw=%b", i, a_aw_ready, a_ar_ready, exp_w); end
      n_checks++; if (a_req_valid !== (i != 0)) begin n_fail++; $display("FAIL alt_req_valid[%0d] got %b exp %b", i, a_req_valid, (i != 0)); end
      if (i != 0) begin
        exp_id = prev_w ? IW'(16 + i - 1) : IW'(32 + i - 1);
        n_checks++; if (a_req_is_wr !== prev_w || a_req_id !== exp_id) begin n_fail++; $display("FAIL alt_payload[%0d] got wr=%b id=%h exp wr=%b id=%h", i, a_req_is_wr, a_req_id, prev_w, exp_id); end
      end
      prev_w = exp_w;
    end
    @(negedge clk);
    aw_valid = 0; ar_valid = 0;
    #1;
    n_checks++; if (a_req_valid !== 1'b1 || a_req_is_wr !== 1'b1 || a_req_len !== 8'd7 || a_req_addr !== 64'h1000_0000_0000_0007) begin n_fail++; $display("FAIL alt_last got v=%b wr=%b len=%h addr=%h exp 1 1 07 1000000000000007", a_req_valid, a_req_is_wr, a_req_len, a_req_addr); end
    @(negedge clk); #1;
    n_checks++; if (a_req_valid !== 1'b0) begin n_fail++; $display("FAIL alt_drain got %b exp 0", a_req_valid); end
    n_checks++; if (a_wr_os_cnt !== 5'd4 || a_rd_os_cnt !== 3'd4) begin n_fail++; $display("FAIL alt_os_cnt got %0d/%0d exp 4/4", a_wr_os_cnt, a_rd_os_cnt); end
  endtask

  // Write weight 3: R,W,W,W,R,W,W,W.
  task automatic test_weighted();
    logic [7:0] pat;
    pat = 8'b1110_1110;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      aw_valid = 1; ar_valid = 1; req_ready = 1;
      aw_id = IW'(16 + i); ar_id = IW'(32 + i);
      aw_addr = AW'(i); ar_addr = AW'(i + 100); aw_len = LW'(i); ar_len = LW'(i);
      #1;
      n_checks++; if (b_aw_ready !== pat[i] || b_ar_ready !== !pat[i]) begin n_fail++; $display("FAIL wrr_grant[%0d] got aw=%b ar=%b exp aw=%b", i, b_aw_ready, b_ar_ready, pat[i]); end
    end
    @(negedge clk);
    aw_valid = 0; ar_valid = 0;
    #1;
    n_checks++; if (b_req_valid !== 1'b1 || b_req_is_wr !== 1'b1 || b_req_id !== 8'd23 || b_req_addr !== 64'd7 || b_req_len !== 8'd7) begin n_fail++; $display("FAIL wrr_last got v=%b wr=%b id=%h addr=%h len=%h exp 1 1 17 7 07", b_req_valid, b_req_is_wr, b_req_id, b_req_addr, b_req_len); end
    n_checks++; if (b_wr_os_cnt !== 5'd6 || b_rd_os_cnt !== 5'd2) begin n_fail++; $display("FAIL wrr_os_cnt got %0d/%0d exp 6/2", b_wr_os_cnt, b_rd_os_cnt); end
    n_checks++; if (b_quiesce_done !== 1'b0 || b_os_underflow !== 1'b0) begin n_fail++; $display("FAIL wrr_flags got qd=%b uf=%b exp 0 0", b_quiesce_done, b_os_underflow); end
  endtask

  // Read limit of 4; one r_last_done gives exactly one more grant, one cycle later.
  task automatic test_rd_limit();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ar_valid = 1; req_ready = 1; ar_id = IW'(i);
      #1;
      n_checks++; if (a_ar_ready !== (i < 4)) begin n_fail++; $display("FAIL lim_ar_ready[%0d] got %b exp %b", i, a_ar_ready, (i < 4)); end
    end
    @(negedge clk);
    r_last_done = 1;
    #1;
    n_checks++; if (a_ar_ready !== 1'b0 || a_rd_os_cnt !== 3'd4) begin n_fail++; $display("FAIL lim_no_bypass got rdy=%b cnt=%0d exp 0 4", a_ar_ready, a_rd_os_cnt); end
    @(negedge clk);
    r_last_done = 0;
    #1;
    n_checks++; if (a_ar_ready !== 1'b1 || a_rd_os_cnt !== 3'd3) begin n_fail++; $display("FAIL lim_credit got rdy=%b cnt=%0d exp 1 3", a_ar_ready, a_rd_os_cnt); end
    @(negedge clk); #1;
    n_checks++; if (a_ar_ready !== 1'b0 || a_rd_os_cnt !== 3'd4) begin n_fail++; $display("FAIL lim_refill got rdy=%b cnt=%0d exp 0 4", a_ar_ready, a_rd_os_cnt); end
    ar_valid = 0;
  endtask

  // Backpressure: held write stays stable; on req_ready the next grant is in the same cycle.
  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk);
    aw_valid = 1; req_ready = 0; aw_id = 8'h5A; aw_addr = 64'hDEAD_BEEF_0000_0040; aw_len = 8'h07;
    #1;
    n_checks++; if (a_aw_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %b exp 1", a_aw_ready); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      aw_id = 8'h6B; aw_addr = 64'h1111; aw_len = 8'h03;
      ar_valid = 1; ar_id = 8'h7C; ar_addr = 64'h2222; ar_len = 8'h01;
      #1;
      n_checks++; if (a_aw_ready !== 1'b0 || a_ar_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_rdy[%0d] got %b%b exp 00", i, a_aw_ready, a_ar_ready); end
      n_checks++; if (a_req_valid !== 1'b1 || a_req_is_wr !== 1'b1 || a_req_id !== 8'h5A || a_req_addr !== 64'hDEAD_BEEF_0000_0040 || a_req_len !== 8'h07) begin n_fail++; $display("FAIL b2b_hold[%0d] got v=%b wr=%b id=%h addr=%h len=%h", i, a_req_valid, a_req_is_wr, a_req_id, a_req_addr, a_req_len); end
    end
    @(negedge clk);
    req_ready = 1;
    #1;
    n_checks++; if (a_ar_ready !== 1'b1 || a_aw_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_regrant got aw=%b ar=%b exp 0 1", a_aw_ready, a_ar_ready); end
    @(negedge clk);
    aw_valid = 0; ar_valid = 0;
    #1;
    n_checks++; if (a_req_valid !== 1'b1 || a_req_is_wr !== 1'b0 || a_req_id !== 8'h7C || a_req_addr !== 64'h2222) begin n_fail++; $display("FAIL b2b_next got v=%b wr=%b id=%h addr=%h exp 1 0 7c 2222", a_req_valid, a_req_is_wr, a_req_id, a_req_addr); end
    @(negedge clk); #1;
    n_checks++; if (a_req_valid !== 1'b0 || a_wr_os_cnt !== 5'd1 || a_rd_os_cnt !== 3'd1) begin n_fail++; $display("FAIL b2b_end got v=%b os=%0d/%0d exp 0 1/1", a_req_valid, a_wr_os_cnt, a_rd_os_cnt); end
  endtask

  // Quiesce with 2 writes and 1 read outstanding.
  task automatic test_quiesce();
    apply_reset();
    @(negedge clk); aw_valid = 1; ar_valid = 1; req_ready = 1;
    @(negedge clk); ar_valid = 0;
    @(negedge clk);
    @(negedge clk);
    quiesce_req = 1; aw_valid = 1; ar_valid = 1;
    #1;
    n_checks++; if (a_aw_ready !== 1'b0 || a_ar_ready !== 1'b0 || a_req_valid !== 1'b1) begin n_fail++; $display("FAIL qsc_block got aw=%b ar=%b v=%b exp 0 0 1", a_aw_ready, a_ar_ready, a_req_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_done = (i < 2); r_last_done = (i == 2);
      #1;
      n_checks++; if (a_quiesce_done !== 1'b0 || a_req_valid !== 1'b0 || a_aw_ready !== 1'b0 || a_ar_ready !== 1'b0) begin n_fail++; $display("FAIL qsc_drain[%0d] got qd=%b v=%b aw=%b ar=%b exp 0000", i, a_quiesce_done, a_req_valid, a_aw_ready, a_ar_ready); end
    end
    @(negedge clk);
    b_done = 0; r_last_done = 0;
    #1;
    n_checks++; if (a_quiesce_done !== 1'b0 || a_wr_os_cnt !== 5'd0 || a_rd_os_cnt !== 3'd0) begin n_fail++; $display("FAIL qsc_zero got qd=%b os=%0d/%0d exp 0 0/0", a_quiesce_done, a_wr_os_cnt, a_rd_os_cnt); end
    @(negedge clk);
    #1;
    n_checks++; if (a_quiesce_done !== 1'b1) begin n_fail++; $display("FAIL qsc_done got %b exp 1", a_quiesce_done); end
    quiesce_req = 0; aw_valid = 0; ar_valid = 0;
    @(negedge clk); #1;
    n_checks++; if (a_quiesce_done !== 1'b0) begin n_fail++; $display("FAIL qsc_release got %b exp 0", a_quiesce_done); end
  endtask

  // Underflow is sticky; reset mid-burst clears everything.
  task automatic test_underflow_reset();
    apply_reset();
    @(negedge clk); b_done = 1;
    @(negedge clk); b_done = 0;
    #1;
    n_checks++; if (a_wr_os_cnt !== 5'd0 || a_os_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set got cnt=%0d uf=%b exp 0 1", a_wr_os_cnt, a_os_underflow); end
    @(negedge clk);
    aw_valid = 1; req_ready = 1; aw_id = 8'h33; aw_addr = 64'h3333; aw_len = 8'h0F;
    @(negedge clk);
    aw_valid = 0; ar_valid = 1; ar_id = 8'h44; ar_addr = 64'h4444; ar_len = 8'h02;
    @(negedge clk);
    #1;
    n_checks++; if (a_req_valid !== 1'b1 || a_req_is_wr !== 1'b0 || a_os_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_burst got v=%b wr=%b uf=%b exp 1 0 1", a_req_valid, a_req_is_wr, a_os_underflow); end
    rst = 1;
    @(negedge clk);
    aw_valid = 0; ar_valid = 0;
    #1;
    n_checks++; if (a_req_valid !== 1'b0 || a_req_is_wr !== 1'b0 || a_req_id !== '0 || a_req_addr !== '0 || a_req_len !== '0) begin n_fail++; $display("FAIL mid_rst_req got v=%b wr=%b id=%h addr=%h len=%h exp all 0", a_req_valid, a_req_is_wr, a_req_id, a_req_addr, a_req_len); end
    n_checks++; if (a_wr_os_cnt !== '0 || a_rd_os_cnt !== '0 || a_os_underflow !== 1'b0 || a_quiesce_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state got os=%0d/%0d uf=%b qd=%b exp 0/0 0 0", a_wr_os_cnt, a_rd_os_cnt, a_os_underflow, a_quiesce_done); end
    rst = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_alternate();
    test_weighted();
    test_rd_limit();
    test_back_to_back();
    test_quiesce();
    test_underflow_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
